// File: rtl/pp_reduce_pkg.sv
// pp_reduce_pkg: shared state type and sizing helpers
// for the sequential Booth partial-product reducer.
package pp_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESOLVE,
    OUT
  } state_e;

  function automatic int nstep(input int count);
    return (count + 1) / 2;
  endfunction

  function automatic int step_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/pp_seq_reducer_csa.sv
// csa_4to2: two cascaded 3:2 carry-save rows; both carry
// vectors are shifted left one place and truncated to WIDTH.
module csa_4to2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] m1;
  logic [WIDTH-1:0] c1;
  logic [WIDTH-1:0] m2;

  always_comb begin
    s1      = a_i ^ b_i ^ c_i;
    m1      = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    c1      = m1 << 1;
    sum_o   = s1 ^ c1 ^ d_i;
    m2      = (s1 & c1) | (s1 & d_i) | (c1 & d_i);
    carry_o = m2 << 1;
  end

endmodule

// File: rtl/pp_seq_reducer.sv
// pp_seq_reducer: folds one bundle of radix-4 Booth partial
// products through a single 4:2 compressor, two per cycle.
module pp_seq_reducer
  import pp_reduce_pkg::*;
#(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16,
  parameter int COUNT   = (WIDTH_B + 2) / 2,
  parameter int WIDTH_O = WIDTH_A + WIDTH_B,
  parameter int NSTEP   = nstep(COUNT)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [COUNT-1:0][WIDTH_O-1:0]   partial_prods_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [WIDTH_O-1:0]              product_o
);

  localparam int SW = step_w(NSTEP);

  state_e                       state_q, state_d;
  logic [SW-1:0]                step_q, step_d;
  logic [COUNT-1:0][WIDTH_O-1:0] pp_q, pp_d;
  logic [WIDTH_O-1:0]           sum_q, sum_d;
  logic [WIDTH_O-1:0]           carry_q, carry_d;
  logic [WIDTH_O-1:0]           product_q, product_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;

  logic [WIDTH_O-1:0] op0, op1;
  logic [WIDTH_O-1:0] csa_sum, csa_carry;

  // Slots past COUNT read as zero when COUNT is odd.
  always_comb begin
    op0 = '0;
    op1 = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (i == 2 * int'(step_q))     op0 = pp_q[i];
      if (i == 2 * int'(step_q) + 1) op1 = pp_q[i];
    end
  end

  csa_4to2 #(
    .WIDTH (WIDTH_O)
  ) u_csa (
    .a_i     (sum_q),
    .b_i     (carry_q),
    .c_i     (op0),
    .d_i     (op1),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    pp_d      = pp_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          pp_d    = partial_prods_i;
          sum_d   = '0;
          carry_d = '0;
          step_d  = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        sum_d   = csa_sum;
        carry_d = csa_carry;
        step_d  = step_q + SW'(1);
        if (step_q == SW'(NSTEP - 1)) state_d = RESOLVE;
      end
      RESOLVE: begin
        product_d = sum_q + carry_q;
        state_d   = OUT;
      end
      OUT: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      step_q      <= '0;
      pp_q        <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      pp_q        <= pp_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign product_o   = product_q;

endmodule
